// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches the keyboard clock, frames
// 11-bit words, and folds E0/F0 prefixes into flags on the following scan code.
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       is_break,
    output logic       is_extended,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic [FW-1:0] flt_cnt;
    logic          clk_flt, clk_flt_q;
    logic          fall;

    logic [1:0]    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] to_cnt;
    logic          pend_brk, pend_ext;
    logic          par_ok;
    logic          timeout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // The filtered clock flips only after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flt_cnt   <= '0;
            clk_flt   <= 1'b1;
            clk_flt_q <= 1'b1;
        end else begin
            clk_flt_q <= clk_flt;
            if (clk_s2 == clk_flt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_flt <= clk_s2;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    assign fall    = clk_flt_q & ~clk_flt;
    assign par_ok  = ^{shreg, par_bit};
    assign timeout = (state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES));
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            to_cnt      <= '0;
            pend_brk    <= 1'b0;
            pend_ext    <= 1'b0;
            scan_code   <= '0;
            is_break    <= 1'b0;
            is_extended <= 1'b0;
            code_valid  <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;

            if (state == IDLE || fall)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;

            // A stalled frame is dropped but any prefix already seen stays pending.
            if (timeout) begin
                state     <= IDLE;
                frame_err <= 1'b1;
                to_cnt    <= '0;
            end else if (fall) begin
                case (state)
                    IDLE: begin
                        if (!dat_s2) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= dat_s2;
                        state   <= STOP;
                    end
                    default: begin
                        state <= IDLE;
                        if (!dat_s2) begin
                            frame_err <= 1'b1;
                        end else if (!par_ok) begin
                            parity_err <= 1'b1;
                            pend_brk   <= 1'b0;
                            pend_ext   <= 1'b0;
                        end else if (shreg == 8'hE0) begin
                            pend_ext <= 1'b1;
                        end else if (shreg == 8'hF0) begin
                            pend_brk <= 1'b1;
                        end else begin
                            scan_code   <= shreg;
                            is_break    <= pend_brk;
                            is_extended <= pend_ext;
                            code_valid  <= 1'b1;
                            pend_brk    <= 1'b0;
                            pend_ext    <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: a byte-level model queues expected output
// events, and a monitor records what the receiver actually emits.
module tb_ps2_keyboard_rx;

    localparam int T    = 2000;
    localparam int HALF = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scan_code;
    logic       code_valid, is_break, is_extended, parity_err, frame_err, busy;

    ps2_keyboard_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .scan_code(scan_code), .code_valid(code_valid), .is_break(is_break),
        .is_extended(is_extended), .parity_err(parity_err), .frame_err(frame_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] kind;   // 1 code, 2 parity error, 3 frame error
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ev_t;

    int  cyc = 0;
    ev_t obs_arr [0:63];
    int  obs_cyc [0:63];
    int  obs_n = 0;
    int  multi_hot = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if ((code_valid | parity_err | frame_err) && obs_n < 64) begin
            obs_arr[obs_n] <= {(code_valid ? 2'd1 : parity_err ? 2'd2 : 2'd3),
                               scan_code, is_break, is_extended};
            obs_cyc[obs_n] <= cyc;
            obs_n          <= obs_n + 1;
        end
        if (int'(code_valid) + int'(parity_err) + int'(frame_err) > 1)
            multi_hot <= multi_hot + 1;
    end

    ev_t        exp_q[$];
    int         vectors = 0, miscompares = 0, rd_idx = 0, last_fall = 0;
    logic       pend_brk = 1'b0, pend_ext = 1'b0;
    logic [7:0] last_code = 8'h00;
    logic       last_brk = 1'b0, last_ext = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [10:0] fr, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = fr[i];
            wait_cyc(HALF);
            ps2_clk   = 1'b0;
            last_fall = cyc;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] b, input logic bad);
        logic p;
        p = ~(^b) ^ bad;
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic bad);
        send_bits(frame_of(b, bad), 11);
        wait_cyc(HALF);
        if (bad) begin
            exp_q.push_back({2'd2, last_code, last_brk, last_ext});
            pend_brk = 1'b0;
            pend_ext = 1'b0;
        end else if (b == 8'hE0) begin
            pend_ext = 1'b1;
        end else if (b == 8'hF0) begin
            pend_brk = 1'b1;
        end else begin
            exp_q.push_back({2'd1, b, pend_brk, pend_ext});
            last_code = b;
            last_brk  = pend_brk;
            last_ext  = pend_ext;
            pend_brk  = 1'b0;
            pend_ext  = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        ev_t e;
        wait_cyc(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rd_idx < obs_n) begin
                chk(tag, 32'(obs_arr[rd_idx]), 32'(e));
                rd_idx++;
            end else begin
                chk({tag, "_missing"}, 32'(obs_n), 32'(rd_idx + 1));
            end
        end
        chk({tag, "_extra"}, 32'(obs_n), 32'(rd_idx));
    endtask

    initial begin
        int   n0, delta;
        logic seen, busy_seen;

        wait_cyc(5);
        chk("rst_outputs", {scan_code, code_valid, is_break, is_extended,
                            parity_err, frame_err}, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 1'b1;
        wait_cyc(5);

        send_byte(8'h1C, 1'b0);
        drain("frame_1c");

        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        drain("e0_f0_75");
        send_byte(8'h1C, 1'b0);
        drain("after_break");

        send_byte(8'hE0, 1'b0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'h5A, 1'b0);
        drain("e0_e0_5a");

        send_byte(8'h1C, 1'b1);
        drain("parity");

        // Timeout after 4 data bits; the E0 before it must survive the abort.
        send_byte(8'hE0, 1'b0);
        send_bits(frame_of(8'h29, 1'b0), 5);
        wait_cyc(20);
        chk("to_busy_hi", 32'(busy), 32'h1);
        n0   = obs_n;
        seen = 1'b0;
        for (int k = 0; k < T + 200 && !seen; k++) begin
            @(negedge clk);
            if (obs_n > n0) seen = 1'b1;
        end
        chk("to_seen", 32'(seen), 32'h1);
        if (seen) begin
            delta = obs_cyc[n0] - last_fall;
            chk("to_lat_min", 32'(delta >= T), 32'h1);
            chk("to_lat_max", 32'(delta <= T + 30), 32'h1);
        end
        chk("to_busy_lo", 32'(busy), 32'h0);
        exp_q.push_back({2'd3, last_code, last_brk, last_ext});
        drain("timeout");
        send_byte(8'h29, 1'b0);
        drain("frame_29");

        // Short low glitch on the keyboard clock while data looks like a start bit.
        ps2_data = 1'b0;
        wait_cyc(5);
        n0        = obs_n;
        busy_seen = 1'b0;
        ps2_clk   = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
        end
        ps2_data = 1'b1;
        chk("glitch_busy", 32'(busy_seen), 32'h0);
        chk("glitch_pulses", 32'(obs_n), 32'(n0));

        // Reset in the middle of a frame, then a clean frame.
        send_bits(frame_of(8'h16, 1'b0), 6);
        wait_cyc(10);
        chk("mid_busy", 32'(busy), 32'h1);
        reset = 1'b0;
        wait_cyc(3);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_out", {scan_code, is_break, is_extended}, 32'h0);
        last_code = 8'h00;
        last_brk  = 1'b0;
        last_ext  = 1'b0;
        pend_brk  = 1'b0;
        pend_ext  = 1'b0;
        reset = 1'b1;
        wait_cyc(10);
        send_byte(8'h16, 1'b0);
        drain("post_reset");

        chk("one_hot", 32'(multi_hot), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
